// File: rtl/eth_sb_pkg.sv
// Shared types and constants for the sideband-to-AXI bridge.
// Holds the FSM state encoding, AXI response codes and the target-decode helper.
// No logic of its own.
package eth_sb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TGT_LOCAL   = 2'd0,
    TGT_BLOCKED = 2'd1,
    TGT_AXI     = 2'd2
  } target_e;

  localparam logic [2:0] RESP_OK     = 3'b000;
  localparam logic [2:0] RESP_SLVERR = 3'b100;
  localparam logic [2:0] RESP_DECERR = 3'b101;

  // Local SRAM wins over flash; a fuse-locked flash hit is refused; everything else goes to AXI.
  function automatic target_e decode_target(input logic loc_mem_map,
                                            input logic flash_en,
                                            input logic fuse_enable);
    if (loc_mem_map)               return TGT_LOCAL;
    else if (flash_en && fuse_enable) return TGT_BLOCKED;
    else                           return TGT_AXI;
  endfunction

endpackage

// File: rtl/eth_sb_axi_fsm.sv
// Bridge from the core sideband valid/ready request to a single-outstanding AXI-lite-style master.
// Latency: local/blocked ready 1 cycle after valid sampled; AXI ready one cycle after svalid is sampled.
// Backpressure: new AXI issue waits in IDLE while i_fifo_full; the slave throttles via saccept/svalid.
module eth_sb_axi_fsm
  import eth_sb_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_fuse_enable,
  input  logic                  i_fifo_full,
  input  logic                  i_fifo_empty,
  input  logic                  i_dec_flash_en,
  input  logic                  i_dec_axi_en,
  input  logic                  i_dec_loc_mem_map,
  input  logic [3:0]            i_core_wstrb,
  input  logic [ADDR_WIDTH-1:0] i_core_addr,
  input  logic                  i_core_valid,
  input  logic [DATA_WIDTH-1:0] i_core_wdata,
  input  logic [2:0]            i_axi_sresp,
  input  logic [DATA_WIDTH-1:0] i_axi_sdata,
  input  logic                  i_axi_svalid,
  input  logic                  i_axi_saccept,
  output logic [DATA_WIDTH-1:0] o_core_rdata,
  output logic [DATA_WIDTH-1:0] o_sram_wr_data,
  output logic                  o_core_ready,
  output logic                  o_axi_mread,
  output logic                  o_axi_mwrite,
  output logic [ADDR_WIDTH-1:0] o_axi_maddr,
  output logic [DATA_WIDTH-1:0] o_axi_mdata,
  output logic                  o_axi_mready,
  output logic [3:0]            o_axi_mwstrb,
  output logic                  o_axi_slverr,
  output logic                  o_axi_decoderr
);

  state_e  state;
  target_e tgt;
  logic    is_wr;
  logic    accept;

  // fifo_empty is reserved and AXI is the fallback target, so these two decoder inputs carry no information.
  logic unused_inputs;
  assign unused_inputs = i_fifo_empty ^ i_dec_axi_en;

  // Decode the incoming request; only AXI-bound requests are held off by a full FIFO.
  always_comb begin
    tgt    = decode_target(i_dec_loc_mem_map, i_dec_flash_en, i_fuse_enable);
    is_wr  = |i_core_wstrb;
    accept = i_core_valid && ((tgt != TGT_AXI) || !i_fifo_full);
  end

  // Transaction FSM; every output is a register updated only here.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= IDLE;
      o_core_rdata   <= '0;
      o_sram_wr_data <= '0;
      o_core_ready   <= 1'b0;
      o_axi_mread    <= 1'b0;
      o_axi_mwrite   <= 1'b0;
      o_axi_maddr    <= '0;
      o_axi_mdata    <= '0;
      o_axi_mready   <= 1'b0;
      o_axi_mwstrb   <= '0;
      o_axi_slverr   <= 1'b0;
      o_axi_decoderr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            o_axi_maddr  <= i_core_addr;
            o_axi_mdata  <= i_core_wdata;
            o_axi_mwstrb <= i_core_wstrb;
            case (tgt)
              TGT_LOCAL: begin
                if (is_wr) o_sram_wr_data <= i_core_wdata;
                else       o_core_rdata   <= '0;
                o_core_ready <= 1'b1;
                state        <= DONE;
              end
              TGT_BLOCKED: begin
                o_axi_decoderr <= 1'b1;
                o_core_ready   <= 1'b1;
                state          <= DONE;
              end
              default: begin
                o_axi_mread  <= !is_wr;
                o_axi_mwrite <= is_wr;
                state        <= REQ;
              end
            endcase
          end
        end

        REQ: begin
          // Command stays asserted until the slave takes it; early responses are ignored.
          if (i_axi_saccept) begin
            o_axi_mready <= 1'b1;
            state        <= WAIT_RESP;
          end
        end

        WAIT_RESP: begin
          if (i_axi_svalid) begin
            o_axi_mready <= 1'b0;
            o_core_ready <= 1'b1;
            state        <= DONE;
            if (i_axi_sresp == RESP_OK) begin
              if (o_axi_mread) o_core_rdata <= i_axi_sdata;
            end else begin
              if (i_axi_sresp == RESP_DECERR) o_axi_decoderr <= 1'b1;
              else                            o_axi_slverr   <= 1'b1;
              if (o_axi_mread) o_core_rdata <= '0;
            end
          end
        end

        DONE: begin
          // Single-cycle completion; command fields stay put so the core can inspect them.
          o_core_ready   <= 1'b0;
          o_axi_mread    <= 1'b0;
          o_axi_mwrite   <= 1'b0;
          o_axi_slverr   <= 1'b0;
          o_axi_decoderr <= 1'b0;
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_sb_axi_fsm.sv
// Self-checking bench for eth_sb_axi_fsm: directed cases then randomized transactions.
// Expected results come from a transaction-level model of the bridge rules.
// Slave handshakes are driven with random delays and random junk on ignored cycles.
module tb_eth_sb_axi_fsm;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_fuse_enable, i_fifo_full, i_fifo_empty;
  logic        i_dec_flash_en, i_dec_axi_en, i_dec_loc_mem_map;
  logic [3:0]  i_core_wstrb;
  logic [23:0] i_core_addr;
  logic        i_core_valid;
  logic [31:0] i_core_wdata;
  logic [2:0]  i_axi_sresp;
  logic [31:0] i_axi_sdata;
  logic        i_axi_svalid, i_axi_saccept;
  logic [31:0] o_core_rdata, o_sram_wr_data, o_axi_mdata;
  logic        o_core_ready, o_axi_mread, o_axi_mwrite, o_axi_mready;
  logic [23:0] o_axi_maddr;
  logic [3:0]  o_axi_mwstrb;
  logic        o_axi_slverr, o_axi_decoderr;

  int total = 0;
  int bad   = 0;

  // Model of the core-visible registers that persist between transactions.
  logic [31:0] m_rdata;
  logic [31:0] m_sram;

  always #5 i_clk = ~i_clk;

  eth_sb_axi_fsm #(.ADDR_WIDTH(24), .DATA_WIDTH(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_fuse_enable(i_fuse_enable), .i_fifo_full(i_fifo_full), .i_fifo_empty(i_fifo_empty),
    .i_dec_flash_en(i_dec_flash_en), .i_dec_axi_en(i_dec_axi_en),
    .i_dec_loc_mem_map(i_dec_loc_mem_map),
    .i_core_wstrb(i_core_wstrb), .i_core_addr(i_core_addr), .i_core_valid(i_core_valid),
    .i_core_wdata(i_core_wdata),
    .i_axi_sresp(i_axi_sresp), .i_axi_sdata(i_axi_sdata), .i_axi_svalid(i_axi_svalid),
    .i_axi_saccept(i_axi_saccept),
    .o_core_rdata(o_core_rdata), .o_sram_wr_data(o_sram_wr_data), .o_core_ready(o_core_ready),
    .o_axi_mread(o_axi_mread), .o_axi_mwrite(o_axi_mwrite), .o_axi_maddr(o_axi_maddr),
    .o_axi_mdata(o_axi_mdata), .o_axi_mready(o_axi_mready), .o_axi_mwstrb(o_axi_mwstrb),
    .o_axi_slverr(o_axi_slverr), .o_axi_decoderr(o_axi_decoderr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    i_fuse_enable = 0; i_fifo_full = 0; i_fifo_empty = 0;
    i_dec_flash_en = 0; i_dec_axi_en = 0; i_dec_loc_mem_map = 0;
    i_core_wstrb = 0; i_core_addr = 0; i_core_valid = 0; i_core_wdata = 0;
    i_axi_sresp = 0; i_axi_sdata = 0; i_axi_svalid = 0; i_axi_saccept = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, o_core_rdata, 0);
    check({tag, "_sram"}, o_sram_wr_data, 0);
    check({tag, "_maddr"}, o_axi_maddr, 0);
    check({tag, "_mdata"}, o_axi_mdata, 0);
    check({tag, "_ctl"}, {o_core_ready, o_axi_mread, o_axi_mwrite, o_axi_mready,
                          o_axi_mwstrb, o_axi_slverr, o_axi_decoderr}, 0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset = 1;
    idle_inputs();
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 0;
    m_rdata = 0;
    m_sram  = 0;
  endtask

  // One complete core request. acc/rdl are the cycles the slave waits before saccept/svalid.
  task automatic run_txn(input string tag, input bit loc, input bit flash, input bit fuse,
                         input logic [23:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input int stall, input int acc, input int rdl,
                         input logic [2:0] rsp, input logic [31:0] sd);
    bit is_rd, axi, exp_slv, exp_dec;
    int exp_lat, k;
    is_rd   = (ws == 4'h0);
    axi     = !loc && !(flash && fuse);
    exp_slv = 0;
    exp_dec = 0;
    if (loc) begin
      if (is_rd) m_rdata = 0; else m_sram = wd;
    end else if (flash && fuse) begin
      exp_dec = 1;
    end else if (rsp == 3'b000) begin
      if (is_rd) m_rdata = sd;
    end else begin
      if (rsp == 3'b101) exp_dec = 1; else exp_slv = 1;
      if (is_rd) m_rdata = 0;
    end
    exp_lat = axi ? acc + rdl + 3 : 1;

    @(negedge i_clk);
    i_core_valid = 1; i_core_addr = a; i_core_wdata = wd; i_core_wstrb = ws;
    i_dec_loc_mem_map = loc; i_dec_flash_en = flash; i_fuse_enable = fuse;
    i_dec_axi_en = 1'($urandom); i_fifo_empty = 1'($urandom);
    if (axi) begin
      i_fifo_full = (stall > 0);
      for (int s = 0; s < stall; s++) begin
        @(posedge i_clk);
        @(negedge i_clk);
        check({tag, "_stall"}, {o_core_ready, o_axi_mread, o_axi_mwrite}, 0);
      end
      i_fifo_full = 0;
    end else begin
      i_fifo_full = 1'($urandom);
    end
    @(posedge i_clk);

    k = 0;
    forever begin
      @(negedge i_clk);
      if (o_core_ready || k >= 40) break;
      i_fifo_full = 1'($urandom);
      if (axi) begin
        if (k == 0) check({tag, "_cmd"}, {o_axi_mread, o_axi_mwrite, o_axi_maddr}, {is_rd, !is_rd, a});
        if (k <= acc) begin
          i_axi_saccept = (k == acc);
          i_axi_svalid  = 1'($urandom);
          i_axi_sresp   = 3'($urandom);
          i_axi_sdata   = $urandom;
        end else begin
          if (k == acc + 1) check({tag, "_mready"}, o_axi_mready, 1);
          i_axi_saccept = 0;
          i_axi_svalid  = (k == acc + 1 + rdl);
          i_axi_sresp   = i_axi_svalid ? rsp : 3'($urandom);
          i_axi_sdata   = i_axi_svalid ? sd  : $urandom;
        end
      end
      @(posedge i_clk);
      k++;
    end
    check({tag, "_lat"}, k + 1, exp_lat);
    if (!o_core_ready) begin
      do_reset();
      return;
    end

    idle_inputs();
    check({tag, "_flags"}, {o_axi_slverr, o_axi_decoderr}, {exp_slv, exp_dec});
    check({tag, "_rdata"}, o_core_rdata, m_rdata);
    check({tag, "_sram"}, o_sram_wr_data, m_sram);
    check({tag, "_done_cmd"}, {o_axi_mread, o_axi_mwrite, o_axi_mready},
          {axi && is_rd, axi && !is_rd, 1'b0});
    check({tag, "_fields"}, {o_axi_maddr, o_axi_mwstrb, o_axi_mdata}, {a, ws, wd});
    @(posedge i_clk);
    @(negedge i_clk);
    check({tag, "_after"}, {o_core_ready, o_axi_mread, o_axi_mwrite, o_axi_slverr, o_axi_decoderr}, 0);
    check({tag, "_hold"}, {o_core_rdata, o_sram_wr_data}, {m_rdata, m_sram});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [2:0] rsp;
    int         r;
    i_reset = 1;
    idle_inputs();
    m_rdata = 0;
    m_sram  = 0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_all_zero("reset");
    i_reset = 0;
    @(negedge i_clk);
    check_all_zero("idle");

    run_txn("axi_rd",  0, 0, 0, 24'h001234, 32'h0,        4'h0, 0, 0, 0, 3'b000, 32'hDEADBEEF);
    run_txn("axi_wr",  0, 0, 0, 24'h005678, 32'hCAFEBABE, 4'hF, 0, 0, 0, 3'b000, 32'h11111111);
    run_txn("slverr",  0, 0, 0, 24'h00ABCD, 32'h0,        4'h0, 0, 0, 0, 3'b100, 32'h55AA55AA);
    run_txn("sram_wr", 1, 0, 0, 24'h000100, 32'h12345678, 4'hF, 0, 0, 0, 3'b000, 32'h0);
    run_txn("flash",   0, 1, 1, 24'h800000, 32'h0,        4'h0, 0, 0, 0, 3'b000, 32'h0);
    run_txn("decerr",  0, 0, 0, 24'h000040, 32'h0,        4'h0, 0, 1, 2, 3'b101, 32'h77777777);
    run_txn("stall",   0, 0, 0, 24'h000200, 32'h0,        4'h0, 3, 0, 0, 3'b000, 32'hA5A5A5A5);

    // Reset while waiting for the response aborts the access with no ready.
    @(negedge i_clk);
    i_core_valid = 1; i_core_addr = 24'h000300; i_core_wstrb = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_core_valid = 0;
    i_axi_saccept = 1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_axi_saccept = 0;
    check("mid_mready", o_axi_mready, 1);
    i_reset = 1;
    @(posedge i_clk);
    @(negedge i_clk);
    check_all_zero("mid_rst");
    i_reset = 0;
    m_rdata = 0;
    m_sram  = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("post_rst_ready", o_core_ready, 0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 3);
      rsp = (r == 0) ? 3'b000 : (r == 1) ? 3'b100 : (r == 2) ? 3'b101 : 3'($urandom_range(1, 7));
      run_txn("rnd", ($urandom % 4) == 0, 1'($urandom), 1'($urandom),
              24'($urandom), $urandom,
              ($urandom % 2) ? 4'h0 : 4'($urandom_range(1, 15)),
              $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
              rsp, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
